// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one word-wide memory bus between the instruction-fetch port and the
//   data (lw/sw) port. Accesses are serialised onto a fixed-latency memory;
//   data accesses have priority, and a starvation counter forces a pending
//   fetch through after STARVE_LIMIT consecutive data grants.
//
// Parameters
//   MEM_LATENCY   cycles one memory access occupies (1..15)
//   STARVE_LIMIT  data grants allowed while a fetch waits (1..255)
//
// Ports
//   mem_arb_clk, mem_arb_rst            clock, synchronous active-high reset
//   mem_arb_if_req/addr/ack/rdata       instruction-fetch port
//   mem_arb_d_req/wr/addr/wdata/ack/rdata  data port
//   mem_arb_mem_addr/wdata/rd/wr/rdata  memory bus
//   mem_arb_busy                        1 while not IDLE
//   mem_arb_owner                       current or last grant (0 fetch, 1 data)
//
// state  | meaning
// IDLE   | bus free, arbitrate between pending requests
// ACCESS | memory strobe active, latency counter running down
// RESP   | one-cycle acknowledge to the owning port
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        mem_arb_clk,
  input  logic        mem_arb_rst,
  input  logic        mem_arb_if_req,
  input  logic [31:0] mem_arb_if_addr,
  output logic        mem_arb_if_ack,
  output logic [31:0] mem_arb_if_rdata,
  input  logic        mem_arb_d_req,
  input  logic        mem_arb_d_wr,
  input  logic [31:0] mem_arb_d_addr,
  input  logic [31:0] mem_arb_d_wdata,
  output logic        mem_arb_d_ack,
  output logic [31:0] mem_arb_d_rdata,
  output logic [31:0] mem_arb_mem_addr,
  output logic [31:0] mem_arb_mem_wdata,
  output logic        mem_arb_mem_rd,
  output logic        mem_arb_mem_wr,
  input  logic [31:0] mem_arb_mem_rdata,
  output logic        mem_arb_busy,
  output logic        mem_arb_owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [3:0]  r_lat_cnt;
  logic [7:0]  r_starve_cnt;
  logic        r_owner;
  logic        r_if_ack;
  logic        r_d_ack;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic w_any_req;
  logic w_grant_d;
  logic w_grant_wr;

  assign w_any_req  = mem_arb_if_req | mem_arb_d_req;
  // Data wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
  assign w_grant_d  = mem_arb_d_req & ~(mem_arb_if_req & (r_starve_cnt == STARVE_MAX));
  assign w_grant_wr = w_grant_d & mem_arb_d_wr;

  always_ff @(posedge mem_arb_clk) begin
    if (mem_arb_rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= 4'd0;
      r_starve_cnt <= 8'd0;
      r_owner      <= 1'b0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_if_rdata   <= 32'd0;
      r_d_rdata    <= 32'd0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_grant_d;
            r_mem_addr <= w_grant_d ? mem_arb_d_addr : mem_arb_if_addr;
            if (w_grant_wr) r_mem_wdata <= mem_arb_d_wdata;
            r_mem_rd   <= ~w_grant_wr;
            r_mem_wr   <= w_grant_wr;
            r_lat_cnt  <= LAT_M1;
            // Counts only data grants that bypassed a waiting fetch.
            if (w_grant_d && mem_arb_if_req) begin
              if (r_starve_cnt != 8'hFF) r_starve_cnt <= r_starve_cnt + 8'd1;
            end else begin
              r_starve_cnt <= 8'd0;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_lat_cnt == 4'd0) begin
            if (r_mem_rd) begin
              if (r_owner) r_d_rdata  <= mem_arb_mem_rdata;
              else         r_if_rdata <= mem_arb_mem_rdata;
            end
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_if_ack <= ~r_owner;
            r_d_ack  <= r_owner;
            r_state  <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_arb_if_ack    = r_if_ack;
  assign mem_arb_d_ack     = r_d_ack;
  assign mem_arb_if_rdata  = r_if_rdata;
  assign mem_arb_d_rdata   = r_d_rdata;
  assign mem_arb_mem_addr  = r_mem_addr;
  assign mem_arb_mem_wdata = r_mem_wdata;
  assign mem_arb_mem_rd    = r_mem_rd;
  assign mem_arb_mem_wr    = r_mem_wr;
  assign mem_arb_busy      = (r_state != S_IDLE);
  assign mem_arb_owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios plus a randomized run for mem_arbiter. A transaction-level
//   reference model predicts each grant from the arbitration rules and derives
//   the expected bus activity from the grant cycle with plain arithmetic.
module tb_mem_arbiter;
  localparam int LAT    = 3;
  localparam int STARVE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, d_req, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_rd, mem_wr, busy, owner;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)) dut (
    .mem_arb_clk(clk), .mem_arb_rst(rst),
    .mem_arb_if_req(if_req), .mem_arb_if_addr(if_addr),
    .mem_arb_if_ack(if_ack), .mem_arb_if_rdata(if_rdata),
    .mem_arb_d_req(d_req), .mem_arb_d_wr(d_wr), .mem_arb_d_addr(d_addr),
    .mem_arb_d_wdata(d_wdata), .mem_arb_d_ack(d_ack), .mem_arb_d_rdata(d_rdata),
    .mem_arb_mem_addr(mem_addr), .mem_arb_mem_wdata(mem_wdata),
    .mem_arb_mem_rd(mem_rd), .mem_arb_mem_wr(mem_wr), .mem_arb_mem_rdata(mem_rdata),
    .mem_arb_busy(busy), .mem_arb_owner(owner)
  );

  // Memory model: contents are a fixed function of the address, and the real
  // word is only presented in the last strobe cycle (garbage before that).
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C110000;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int scnt = 0;
  always @(posedge clk) scnt <= (mem_rd || mem_wr) ? scnt + 1 : 0;
  assign mem_rdata = (mem_rd && scnt == LAT - 1) ? memf(mem_addr) : (32'hBADB0000 | 32'(scnt));

  // Reference model state
  int          cyc = 0, g_t = -1000, free_at = 0;
  bit          g_d, g_wr;
  logic [31:0] g_addr;
  int          starve = 0;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata;
  bit          m_owner, e_busy, e_rd, e_wr, e_if_ack, e_d_ack;

  // Advance one clock: the model arbitrates on the inputs of the current cycle,
  // then expectations for the following cycle are derived from the last grant.
  task automatic tick();
    bit rst_now;
    rst_now = rst;
    if (!rst_now && cyc >= free_at && (if_req || d_req)) begin
      g_d  = d_req && !(if_req && starve == STARVE);
      g_wr = g_d && d_wr;
      g_addr = g_d ? d_addr : if_addr;
      g_t = cyc;
      if (g_wr) m_wdata = d_wdata;
      m_addr  = g_addr;
      m_owner = g_d;
      if (g_d && if_req) starve = (starve < 255) ? starve + 1 : 255;
      else               starve = 0;
      free_at = cyc + LAT + 2;
    end
    @(posedge clk); #1;
    cyc++;
    if (rst_now) begin
      g_t = -1000; free_at = cyc; starve = 0; m_owner = 1'b0;
      m_addr = '0; m_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    end
    e_busy   = (cyc >= g_t + 1) && (cyc <= g_t + LAT + 1);
    e_rd     = (cyc >= g_t + 1) && (cyc <= g_t + LAT) && !g_wr;
    e_wr     = (cyc >= g_t + 1) && (cyc <= g_t + LAT) && g_wr;
    e_if_ack = (cyc == g_t + LAT + 1) && !g_d;
    e_d_ack  = (cyc == g_t + LAT + 1) && g_d;
    if (cyc == g_t + LAT + 1 && !g_wr) begin
      if (g_d) e_d_rdata  = memf(g_addr);
      else     e_if_rdata = memf(g_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; d_req = 0; d_wr = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    n_checks++;
    if ({busy, mem_rd, mem_wr, if_ack, d_ack, owner} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, mem_rd, mem_wr, if_ack, d_ack, owner});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    int c0, nrd, nbusy, nack, ack_cyc;
    nrd = 0; nbusy = 0; nack = 0; ack_cyc = -1; c0 = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_rd) nrd++;
      if (busy) nbusy++;
      if (if_ack) begin nack++; ack_cyc = cyc; end
      if (e_if_ack) if_req = 1'b0;
    end
    n_checks++;
    if (nrd !== LAT) begin n_fail++; $display("FAIL fetch_rd_cycles got=%0d exp=%0d", nrd, LAT); end
    n_checks++;
    if (nbusy !== LAT + 1) begin n_fail++; $display("FAIL fetch_busy_cycles got=%0d exp=%0d", nbusy, LAT + 1); end
    n_checks++;
    if (nack !== 1 || ack_cyc !== c0 + LAT + 1) begin
      n_fail++; $display("FAIL fetch_ack got=%0d@%0d exp=1@%0d", nack, ack_cyc, c0 + LAT + 1);
    end
    n_checks++;
    if (if_rdata !== 32'h8C110000) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=8c110000", if_rdata); end
  endtask

  task automatic test_data_write();
    int c0, nwr_ok, nrd, nack, ack_cyc;
    nwr_ok = 0; nrd = 0; nack = 0; ack_cyc = -1; c0 = cyc;
    d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_wr && mem_addr == 32'h100 && mem_wdata == 32'hDEADBEEF) nwr_ok++;
      if (mem_rd) nrd++;
      if (d_ack) begin nack++; ack_cyc = cyc; end
      if (e_d_ack) d_req = 1'b0;
    end
    d_wr = 1'b0;
    n_checks++;
    if (nwr_ok !== LAT || nrd !== 0) begin
      n_fail++; $display("FAIL write_strobe got wr=%0d rd=%0d exp wr=%0d rd=0", nwr_ok, nrd, LAT);
    end
    n_checks++;
    if (nack !== 1 || ack_cyc !== c0 + LAT + 1) begin
      n_fail++; $display("FAIL write_ack got=%0d@%0d exp=1@%0d", nack, ack_cyc, c0 + LAT + 1);
    end
    n_checks++;
    if (d_rdata !== 32'd0 || if_rdata !== 32'h8C110000) begin
      n_fail++; $display("FAIL write_rdata_hold got d=%h if=%h exp d=0 if=8c110000", d_rdata, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bit obs[$];
    int starts[$];
    int dack_cyc;
    bit prev;
    prev = 0; dack_cyc = -1;
    if_addr = 32'h20; d_addr = 32'h200; d_wr = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if ((mem_rd || mem_wr) && !prev) begin obs.push_back(owner); starts.push_back(cyc); end
      prev = mem_rd || mem_wr;
      if (d_ack) dack_cyc = cyc;
      if (e_d_ack)  d_req  = 1'b0;
      if (e_if_ack) if_req = 1'b0;
    end
    n_checks++;
    if (obs.size() != 2 || obs[0] !== 1'b1 || obs[1] !== 1'b0) begin
      n_fail++; $display("FAIL simul_order got=%p exp='{1,0}", obs);
    end
    n_checks++;
    if (starts.size() != 2 || starts[1] !== dack_cyc + 2) begin
      n_fail++; $display("FAIL simul_fetch_grant got=%p exp fetch strobe at %0d", starts, dack_cyc + 2);
    end
    n_checks++;
    if (d_rdata !== memf(32'h200) || if_rdata !== memf(32'h20)) begin
      n_fail++; $display("FAIL simul_rdata got d=%h if=%h exp d=%h if=%h", d_rdata, if_rdata, memf(32'h200), memf(32'h20));
    end
  endtask

  task automatic test_starvation();
    bit obs[$];
    bit exp_seq[6] = '{1, 1, 0, 1, 1, 0};
    bit prev, done;
    prev = 0; done = 0;
    if_addr = 32'h400; d_addr = 32'h300; d_wr = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if ((mem_rd || mem_wr) && !prev) obs.push_back(owner);
      prev = mem_rd || mem_wr;
      if (obs.size() >= 6) done = 1;
      if (e_d_ack || done) d_req = 1'b0;
      else if (!d_req) begin d_req = 1'b1; d_addr = d_addr + 32'd4; end
      if (e_if_ack) begin
        if (done) if_req = 1'b0;
        else      if_addr = if_addr + 32'd4;
      end
    end
    n_checks++;
    if (obs.size() != 6) begin n_fail++; $display("FAIL starve_count got=%0d exp=6", obs.size()); end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= obs.size() || obs[k] !== exp_seq[k]) begin
        n_fail++; $display("FAIL starve_order idx=%0d got=%p exp='{1,1,0,1,1,0}", k, obs);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int nack;
    nack = 0;
    if_addr = 32'h40; if_req = 1'b1;
    tick();            // first ACCESS cycle
    tick();            // second ACCESS cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, mem_rd, mem_wr, if_ack, d_ack, owner} !== 6'b0 || mem_addr !== 32'd0 || if_rdata !== 32'd0) begin
      n_fail++; $display("FAIL midrst_state got ctrl=%b addr=%h ifr=%h exp 0", {busy, mem_rd, mem_wr, if_ack, d_ack, owner}, mem_addr, if_rdata);
    end
    if_req = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (if_ack) nack++; end
    n_checks++;
    if (nack !== 0) begin n_fail++; $display("FAIL midrst_no_ack got=%0d exp=0", nack); end
    if_addr = 32'h44; if_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (if_ack) nack++;
      if (e_if_ack) if_req = 1'b0;
    end
    n_checks++;
    if (nack !== 1 || if_rdata !== memf(32'h44)) begin
      n_fail++; $display("FAIL midrst_recover got ack=%0d rdata=%h exp ack=1 rdata=%h", nack, if_rdata, memf(32'h44));
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int k;
    k = 0;
    if_addr = 32'h1000; if_req = 1'b1;
    for (int i = 0; i < 40 && k < 4; i++) begin
      tick();
      if (if_ack) begin
        acks.push_back(cyc);
        n_checks++;
        if (if_rdata !== memf(32'h1000 + 32'(4 * k))) begin
          n_fail++; $display("FAIL b2b_rdata idx=%0d got=%h exp=%h", k, if_rdata, memf(32'h1000 + 32'(4 * k)));
        end
      end
      if (e_if_ack) begin
        k++;
        if (k < 4) if_addr = 32'h1000 + 32'(4 * k);
        else       if_req = 1'b0;
      end
    end
    n_checks++;
    if (acks.size() != 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", acks.size()); end
    for (int j = 1; j < acks.size(); j++) begin
      n_checks++;
      if (acks[j] - acks[j-1] !== LAT + 2) begin
        n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", j, acks[j] - acks[j-1], LAT + 2);
      end
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_checks++;
      if ({busy, mem_rd, mem_wr, if_ack, d_ack, owner} !== {e_busy, e_rd, e_wr, e_if_ack, e_d_ack, m_owner}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {busy, mem_rd, mem_wr, if_ack, d_ack, owner},
                           {e_busy, e_rd, e_wr, e_if_ack, e_d_ack, m_owner});
      end
      n_checks++;
      if ({mem_addr, mem_wdata} !== {m_addr, m_wdata}) begin
        n_fail++; $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata, m_addr, m_wdata);
      end
      n_checks++;
      if ({if_rdata, d_rdata} !== {e_if_rdata, e_d_rdata}) begin
        n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, if_rdata, d_rdata, e_if_rdata, e_d_rdata);
      end
      rst = ($urandom_range(0, 99) == 0);
      if (e_if_ack) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
      if (e_d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_wr = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
